jtag_tap_driver: RTL and testbench
==================================

# jtag_tap_driver

Host-side JTAG scan driver: accepts IR-scan, DR-scan, TAP-reset and idle commands on a valid/ready interface and generates the TMS/TDI sequence that walks the target TAP controller through the matching 1149.1 states, capturing TDO bit-by-bit. It is the initiator for the target-side instruction and data registers. Board-level and bench-level test masters use it in place of an external probe.

## Interface
Parameters:
- IR_LEN, 5: target instruction register length in bits.
- MAX_LEN, 32: maximum DR scan length; also the width of cmd_data and rsp_data.

Ports:
- TCK  in  1  scan clock; all state changes on posedge TCK.
- TRST  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver idle and able to accept.
- cmd_type  in  2  00 IR scan, 01 DR scan, 10 TAP reset, 11 idle run.
- cmd_len  in  $clog2(MAX_LEN)  DR length or idle count; 0 means MAX_LEN. Ignored for IR and reset.
- cmd_data  in  MAX_LEN  bits to shift in, LSB first.
- TMS  out  1  registered test mode select to target.
- TDI  out  1  registered test data to target.
- TDO  in  1  test data from target; sampled on posedge TCK.
- rsp_valid  out  1  one-cycle pulse at command completion.
- rsp_data  out  MAX_LEN  captured TDO bits, LSB = first bit out; unused upper bits 0.
- ir_capture_err  out  1  valid with rsp_valid; see Configuration.

## Operation
- FSM tracks the target TAP state in lockstep: states RESET, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, plus RUN (idle-count).
- TMS/TDI registered. The value driven after edge k is sampled by the target at edge k+1.
- cmd_ready = 1 only in IDLE with TMS = 0. Command accepted on a posedge with cmd_valid && cmd_ready. cmd_data, cmd_len and cmd_type are latched at acceptance; inputs are don't-care afterwards.
- The acceptance edge itself is a Run-Test/Idle edge (TMS = 0).
- IR scan, TMS sequence on the edges after acceptance: 1, 1, 0, 0. Then N = IR_LEN shift edges, TMS 0 on all except the last, which is 1. Then 1 (Exit1→Update) and 0 (Update→Idle). Total IR_LEN + 6 edges.
- DR scan: 1, 0, 0, then N = cmd_len shift edges (last TMS = 1), then 1 and 0. Total N + 5 edges.
- On shift edge i (0-based): TDI = cmd_data[i] is driven, and TDO is sampled into rsp_data[i].
- TAP reset: 5 edges TMS = 1, then 1 edge TMS = 0. rsp_data = 0.
- Idle run: cmd_len edges with TMS = 0, FSM in RUN. rsp_data = 0.
- On the edge returning to IDLE: rsp_valid = 1 for one cycle, rsp_data is held until the next acceptance, and cmd_ready = 1 in the same cycle.
- rsp_valid has no backpressure.
- TDI = 0 whenever the target is not in SHIFT.

## Timing
- Reset (TRST low, asynchronous): FSM = RESET, TMS = 1, TDI = 0, cmd_ready = 0, rsp_valid = 0, rsp_data = 0, ir_capture_err = 0, internal counters = 0.
- After TRST deasserts: 5 edges TMS = 1, then 1 edge TMS = 0, then IDLE with cmd_ready = 1. No rsp_valid is generated for this start-up reset.
- Latency from the acceptance edge to the rsp_valid edge: IR = IR_LEN + 6, DR = len + 5, reset = 6, idle = len.
- Back-to-back commands: minimum spacing is one Run-Test/Idle edge, which is the acceptance edge.
- Shift counter width is $clog2(MAX_LEN) + 1. cmd_len = 0 yields exactly MAX_LEN shifts; no wrap-around.
- TRST asserted mid-command: the command is aborted with no rsp_valid, and the start-up sequence is re-run.
- cmd_valid held during a command: ignored until cmd_ready.

## Configuration
- JTAG_DRV_IRCHK_EN defined: on IR-scan completion, ir_capture_err = (rsp_data[1:0] != 2'b01), the mandatory capture pattern. The flag is held with rsp_data. It is cleared on DR, reset and idle completions.
- JTAG_DRV_IRCHK_EN not defined: ir_capture_err is tied 0 and no compare logic is built.

## Test plan
- TRST pulse, then release → TMS = 1 for 5 edges, then 0; cmd_ready rises on edge 6; target instruction register reads BYPASS.
- IR scan cmd_data = 5'b00010 → rsp_valid on edge 11 after acceptance; rsp_data = 32'h00000001; target parallel_out = 5'b00010; ir_capture_err = 0.
- Target TDO forced 0 during an IR scan with JTAG_DRV_IRCHK_EN → rsp_data = 0, ir_capture_err = 1; the same run without the macro → ir_capture_err = 0.
- DR scan len = 0 against a 32-bit loopback shift register preloaded with 32'hA5A5_5A5A, cmd_data = 32'h1234_5678 → rsp_data = 32'hA5A5_5A5A after 37 edges; register holds 32'h1234_5678.
- Idle run len = 3, immediately followed by a TAP reset → TMS = 0,0,0, rsp_valid, 1 idle edge, then TMS = 1×5, 0; a second rsp_valid with rsp_data = 0.
- TRST asserted on the 3rd shift edge of a DR scan → outputs at reset values immediately; no rsp_valid; the start-up sequence re-runs.

Source files
------------

// File: rtl/jtag_tap_driver.sv
// Host-side JTAG scan driver: walks the target TAP through IR/DR scans, resets and idle runs.
// Optional IR capture-pattern check is built when JTAG_DRV_IRCHK_EN is defined.
module jtag_tap_driver #(
    parameter int unsigned IR_LEN  = 5,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic                       TCK,
    input  logic                       TRST,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_type,
    input  logic [$clog2(MAX_LEN)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]         cmd_data,
    output logic                       TMS,
    output logic                       TDI,
    input  logic                       TDO,
    output logic                       rsp_valid,
    output logic [MAX_LEN-1:0]         rsp_data,
    output logic                       ir_capture_err
);
    localparam int unsigned LW = $clog2(MAX_LEN);
    localparam int unsigned CW = LW + 1;

    localparam logic [1:0] CmdIr  = 2'b00;
    localparam logic [1:0] CmdDr  = 2'b01;
    localparam logic [1:0] CmdRst = 2'b10;
    localparam logic [1:0] CmdRun = 2'b11;

    typedef enum logic [3:0] {
        StReset, StIdle, StSelDr, StSelIr, StCapture, StShift, StExit1, StUpdate, StRun
    } state_e;

    state_e             st_q;
    logic [1:0]         typ_q;
    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      len_q;
    logic [MAX_LEN-1:0] sh_q;
    logic [CW-1:0]      cmd_len_eff;
    logic               last_shift;
    logic               next_last;

    assign cmd_len_eff = (cmd_len == '0) ? CW'(MAX_LEN) : {1'b0, cmd_len};
    assign last_shift  = (cnt_q == len_q - CW'(1));
    assign next_last   = (cnt_q + CW'(2) == len_q);
    assign cmd_ready   = (st_q == StIdle) && !TMS;

    // TMS is always the value the target will sample on the next edge, so each
    // transition loads the TMS required to leave the state just entered.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            st_q      <= StReset;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            typ_q     <= CmdIr;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            len_q     <= '0;
            sh_q      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (st_q)
                StReset: begin
                    cnt_q <= cnt_q + CW'(1);
                    TMS   <= (cnt_q < CW'(4));
                    if (cnt_q == CW'(5)) begin
                        st_q      <= StIdle;
                        cnt_q     <= '0;
                        rsp_valid <= busy_q;
                        busy_q    <= 1'b0;
                    end
                end
                StIdle: begin
                    if (TMS) begin
                        st_q <= StSelDr;
                        TMS  <= (typ_q == CmdIr);
                    end else if (cmd_valid) begin
                        typ_q    <= cmd_type;
                        busy_q   <= 1'b1;
                        sh_q     <= cmd_data;
                        rsp_data <= '0;
                        cnt_q    <= '0;
                        len_q    <= (cmd_type == CmdIr) ? CW'(IR_LEN) : cmd_len_eff;
                        case (cmd_type)
                            CmdRst: begin
                                st_q <= StReset;
                                TMS  <= 1'b1;
                            end
                            CmdRun:  st_q <= StRun;
                            CmdDr:   TMS <= 1'b1;
                            default: TMS <= 1'b1;
                        endcase
                    end
                end
                StSelDr: begin
                    st_q <= (typ_q == CmdIr) ? StSelIr : StCapture;
                    TMS  <= 1'b0;
                end
                StSelIr: begin
                    st_q <= StCapture;
                    TMS  <= 1'b0;
                end
                StCapture: begin
                    st_q  <= StShift;
                    cnt_q <= '0;
                    TMS   <= (len_q == CW'(1));
                    TDI   <= sh_q[0];
                    sh_q  <= sh_q >> 1;
                end
                StShift: begin
                    rsp_data[cnt_q[LW-1:0]] <= TDO;
                    if (last_shift) begin
                        st_q <= StExit1;
                        TMS  <= 1'b1;
                        TDI  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        TMS   <= next_last;
                        TDI   <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                    end
                end
                StExit1: begin
                    st_q <= StUpdate;
                    TMS  <= 1'b0;
                end
                StUpdate: begin
                    st_q      <= StIdle;
                    TMS       <= 1'b0;
                    rsp_valid <= 1'b1;
                    busy_q    <= 1'b0;
                end
                StRun: begin
                    if (cnt_q == len_q - CW'(1)) begin
                        st_q      <= StIdle;
                        cnt_q     <= '0;
                        rsp_valid <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    st_q <= StReset;
                    TMS  <= 1'b1;
                    TDI  <= 1'b0;
                end
            endcase
        end
    end

`ifdef JTAG_DRV_IRCHK_EN
    logic ir_err_q;

    // Every 1149.1 IR captures ...01 into its two LSBs; anything else means a broken chain.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_err_q <= 1'b0;
        end else if (cmd_valid && cmd_ready) begin
            ir_err_q <= 1'b0;
        end else if (st_q == StUpdate && typ_q == CmdIr) begin
            ir_err_q <= (rsp_data[1:0] != 2'b01);
        end
    end

    assign ir_capture_err = ir_err_q;
`else
    assign ir_capture_err = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver against a behavioural 1149.1 TAP target with a
// 5-bit IR (BYPASS = 11111) and a 32-bit data register selected by instruction 00010.
module tb_jtag_tap_driver;
    logic        TCK = 1'b0;
    logic        TRST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = 2'b00;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        cmd_ready, TMS, TDI, TDO, rsp_valid, ir_capture_err;
    logic [31:0] rsp_data;

    int total = 0;
    int bad = 0;

`ifdef JTAG_DRV_IRCHK_EN
    localparam logic EXP_IRERR = 1'b1;
`else
    localparam logic EXP_IRERR = 1'b0;
`endif

    jtag_tap_driver #(.IR_LEN(5), .MAX_LEN(32)) dut (
        .TCK(TCK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ir_capture_err(ir_capture_err)
    );

    always #5 TCK = ~TCK;

    // Target TAP model; starts away from Test-Logic-Reset with a non-BYPASS instruction.
    typedef enum logic [3:0] {
        Tlr, Rti, Sds, Cdr, Sdr, E1d, Pdr, E2d, Udr, Sis, Cir, Sir, E1i, Pir, E2i, Uir
    } tap_e;

    tap_e        tst = Rti;
    logic [4:0]  t_ir = 5'b00010;
    logic [4:0]  t_irsh = 5'b0;
    logic [31:0] t_dr = 32'h0;
    logic [31:0] t_drsh = 32'h0;
    logic        force_tdo0 = 1'b0;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            Tlr: return m ? Tlr : Rti;
            Rti: return m ? Sds : Rti;
            Sds: return m ? Sis : Cdr;
            Cdr: return m ? E1d : Sdr;
            Sdr: return m ? E1d : Sdr;
            E1d: return m ? Udr : Pdr;
            Pdr: return m ? E2d : Pdr;
            E2d: return m ? Udr : Sdr;
            Udr: return m ? Sds : Rti;
            Sis: return m ? Tlr : Cir;
            Cir: return m ? E1i : Sir;
            Sir: return m ? E1i : Sir;
            E1i: return m ? Uir : Pir;
            Pir: return m ? E2i : Pir;
            E2i: return m ? Uir : Sir;
            default: return m ? Sds : Rti;
        endcase
    endfunction

    always @(posedge TCK) begin
        case (tst)
            Tlr: t_ir <= 5'b11111;
            Cir: t_irsh <= 5'b00001;
            Sir: t_irsh <= {TDI, t_irsh[4:1]};
            Uir: t_ir <= t_irsh;
            Cdr: t_drsh <= (t_ir == 5'b00010) ? t_dr : 32'h0;
            Sdr: t_drsh <= (t_ir == 5'b00010) ? {TDI, t_drsh[31:1]} : {31'h0, TDI};
            Udr: if (t_ir == 5'b00010) t_dr <= t_drsh;
            default: ;
        endcase
        tst <= tap_next(tst, TMS);
    end

    assign TDO = force_tdo0 ? 1'b0 : (tst == Sir) ? t_irsh[0] : (tst == Sdr) ? t_drsh[0] : 1'b0;

    logic tms_log [0:63];

    // Issues one command; lat = edges from acceptance to rsp_valid (-1 if none within budget).
    task automatic run_cmd(input logic [1:0] t, input logic [4:0] l, input logic [31:0] d,
                           output int waited, output int lat);
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(posedge TCK); #1;
            waited++;
        end
        cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
        @(posedge TCK); #1;
        cmd_valid = 1'b0; cmd_type = 2'b11; cmd_len = 5'd7; cmd_data = 32'hDEAD_BEEF;
        tms_log[0] = TMS;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge TCK); #1;
            if (n < 64) tms_log[n] = TMS;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] tv, rv;
        logic any_rv;
        @(posedge TCK); #1;
        total++; if ({TMS, TDI, cmd_ready, rsp_valid, ir_capture_err} !== 5'b10000) begin
            bad++; $display("FAIL reset_outputs: got %b want 10000", {TMS, TDI, cmd_ready, rsp_valid, ir_capture_err});
        end
        total++; if (rsp_data !== 32'h0) begin
            bad++; $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data);
        end
        TRST = 1'b1;
        any_rv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge TCK); #1;
            tv[k] = TMS; rv[k] = cmd_ready; any_rv |= rsp_valid;
        end
        total++; if (tv !== 6'b001111) begin
            bad++; $display("FAIL startup_tms: got %b want 001111", tv);
        end
        total++; if (rv !== 6'b100000) begin
            bad++; $display("FAIL startup_ready: got %b want 100000", rv);
        end
        total++; if (any_rv !== 1'b0) begin
            bad++; $display("FAIL startup_no_rsp: got %b want 0", any_rv);
        end
        total++; if (t_ir !== 5'b11111 || tst !== Rti) begin
            bad++; $display("FAIL startup_target: got ir=%b st=%0d want ir=11111 st=%0d", t_ir, tst, Rti);
        end
    endtask

    task automatic test_ir_scan();
        int w, lat;
        logic [10:0] tv;
        run_cmd(2'b00, 5'd0, 32'h0000_0002, w, lat);
        for (int i = 0; i < 11; i++) tv[i] = tms_log[i];
        total++; if (lat != 11) begin
            bad++; $display("FAIL ir_latency: got %0d want 11", lat);
        end
        total++; if (tv !== 11'b01100000011) begin
            bad++; $display("FAIL ir_tms_seq: got %b want 01100000011", tv);
        end
        total++; if (rsp_data !== 32'h0000_0001) begin
            bad++; $display("FAIL ir_rsp_data: got %h want 00000001", rsp_data);
        end
        total++; if (ir_capture_err !== 1'b0) begin
            bad++; $display("FAIL ir_err_clean: got %b want 0", ir_capture_err);
        end
        total++; if (t_ir !== 5'b00010) begin
            bad++; $display("FAIL ir_target_reg: got %b want 00010", t_ir);
        end
        total++; if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL ir_ready_at_rsp: got %b want 1", cmd_ready);
        end
        @(posedge TCK); #1;
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0000_0001) begin
            bad++; $display("FAIL ir_rsp_pulse_hold: got v=%b d=%h want v=0 d=00000001", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_dr_scan();
        int w, lat;
        run_cmd(2'b01, 5'd0, 32'hA5A5_5A5A, w, lat);
        total++; if (lat != 37 || rsp_data !== 32'h0) begin
            bad++; $display("FAIL dr32_load: got lat=%0d d=%h want lat=37 d=00000000", lat, rsp_data);
        end
        run_cmd(2'b01, 5'd0, 32'h1234_5678, w, lat);
        total++; if (lat != 37) begin
            bad++; $display("FAIL dr32_latency: got %0d want 37", lat);
        end
        total++; if (rsp_data !== 32'hA5A5_5A5A) begin
            bad++; $display("FAIL dr32_rsp_data: got %h want a5a55a5a", rsp_data);
        end
        total++; if (t_dr !== 32'h1234_5678) begin
            bad++; $display("FAIL dr32_target_reg: got %h want 12345678", t_dr);
        end
        run_cmd(2'b01, 5'd8, 32'h0000_00AB, w, lat);
        total++; if (lat != 13 || rsp_data !== 32'h0000_0078) begin
            bad++; $display("FAIL dr8_scan: got lat=%0d d=%h want lat=13 d=00000078", lat, rsp_data);
        end
        total++; if (t_dr !== 32'hAB12_3456) begin
            bad++; $display("FAIL dr8_target_reg: got %h want ab123456", t_dr);
        end
    endtask

    task automatic test_back_to_back();
        int w, lat;
        logic [2:0] iv;
        logic [5:0] rv;
        run_cmd(2'b11, 5'd3, 32'h0, w, lat);
        for (int i = 0; i < 3; i++) iv[i] = tms_log[i];
        total++; if (lat != 3 || iv !== 3'b000) begin
            bad++; $display("FAIL idle_run: got lat=%0d tms=%b want lat=3 tms=000", lat, iv);
        end
        total++; if (rsp_data !== 32'h0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL idle_rsp: got d=%h rdy=%b want d=00000000 rdy=1", rsp_data, cmd_ready);
        end
        run_cmd(2'b10, 5'd0, 32'hFFFF_FFFF, w, lat);
        for (int i = 0; i < 6; i++) rv[i] = tms_log[i];
        total++; if (w != 0 || lat != 6) begin
            bad++; $display("FAIL tap_reset_timing: got wait=%0d lat=%0d want wait=0 lat=6", w, lat);
        end
        total++; if (rv !== 6'b011111) begin
            bad++; $display("FAIL tap_reset_tms: got %b want 011111", rv);
        end
        total++; if (rsp_data !== 32'h0 || t_ir !== 5'b11111) begin
            bad++; $display("FAIL tap_reset_result: got d=%h ir=%b want d=00000000 ir=11111", rsp_data, t_ir);
        end
    endtask

    task automatic test_ir_check();
        int w, lat;
        force_tdo0 = 1'b1;
        run_cmd(2'b00, 5'd0, 32'h0000_0002, w, lat);
        force_tdo0 = 1'b0;
        total++; if (lat != 11 || rsp_data !== 32'h0) begin
            bad++; $display("FAIL irchk_rsp: got lat=%0d d=%h want lat=11 d=00000000", lat, rsp_data);
        end
        total++; if (ir_capture_err !== EXP_IRERR) begin
            bad++; $display("FAIL irchk_flag: got %b want %b", ir_capture_err, EXP_IRERR);
        end
        @(posedge TCK); #1;
        total++; if (ir_capture_err !== EXP_IRERR) begin
            bad++; $display("FAIL irchk_flag_held: got %b want %b", ir_capture_err, EXP_IRERR);
        end
        run_cmd(2'b01, 5'd8, 32'h0, w, lat);
        total++; if (ir_capture_err !== 1'b0 || rsp_data !== 32'h0000_0056) begin
            bad++; $display("FAIL irchk_clear_on_dr: got err=%b d=%h want err=0 d=00000056", ir_capture_err, rsp_data);
        end
    endtask

    task automatic test_abort();
        int w;
        logic any_rv;
        logic [5:0] rv;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(posedge TCK); #1;
            w++;
        end
        cmd_type = 2'b01; cmd_len = 5'd8; cmd_data = 32'hFFFF_FFFF; cmd_valid = 1'b1;
        @(posedge TCK); #1;
        cmd_valid = 1'b0;
        any_rv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge TCK); #1;
            any_rv |= rsp_valid;
        end
        total++; if (TDI !== 1'b1 || tst !== Sdr) begin
            bad++; $display("FAIL abort_in_shift: got tdi=%b st=%0d want tdi=1 st=%0d", TDI, tst, Sdr);
        end
        TRST = 1'b0;
        #1;
        total++; if ({TMS, TDI, cmd_ready, rsp_valid, ir_capture_err} !== 5'b10000 || rsp_data !== 32'h0) begin
            bad++; $display("FAIL abort_outputs: got %b d=%h want 10000 d=00000000", {TMS, TDI, cmd_ready, rsp_valid, ir_capture_err}, rsp_data);
        end
        @(posedge TCK); @(posedge TCK); #1;
        TRST = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge TCK); #1;
            rv[k] = cmd_ready; any_rv |= rsp_valid;
        end
        total++; if (rv !== 6'b100000 || any_rv !== 1'b0) begin
            bad++; $display("FAIL abort_restart: got rdy=%b rv=%b want rdy=100000 rv=0", rv, any_rv);
        end
        total++; if (t_ir !== 5'b11111 || tst !== Rti) begin
            bad++; $display("FAIL abort_target: got ir=%b st=%0d want ir=11111 st=%0d", t_ir, tst, Rti);
        end
    endtask

    initial begin
        test_reset();
        test_ir_scan();
        test_dr_scan();
        test_back_to_back();
        test_ir_check();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
